uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
- Serial transmit path of the 16550-compatible UART; the counterpart of the receive path on the same line protocol.
- Accepts bytes from the register file (THR writes) into a transmit FIFO.
- Serialises each byte onto stx_pad_o as start bit, 5–8 data bits LSB first, optional parity bit, then 1/1.5/2 stop bits.
- Timing comes from the 16x baud enable strobe produced by the shared baud generator.

Parameters:
- FIFO_DEPTH, 16, transmit FIFO entries (power of two).
- COUNT_W, 5, width of tf_count; must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock; sole clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- lcr  in  8  line control: [1:0] word length, [2] stop bits, [3] PE, [4] EP, [5] SP, [6] BC.
- wb_dat_i  in  8  byte to enqueue.
- tf_push  in  1  one-clk push strobe for wb_dat_i.
- enable  in  1  16x baud tick, one clk wide.
- tx_reset  in  1  synchronous FIFO flush (FCR bit 2).
- stx_pad_o  out  1  serial output; idles high.
- tf_count  out  COUNT_W  FIFO occupancy.
- tstate  out  3  current FSM state, for debug/LSR.
- tx_empty  out  1  FIFO empty AND FSM idle (LSR TEMT).

Behaviour:
- Reset (async, wb_rst_i=1) values: stx_pad_o=1, tstate=idle, tf_count=0, tx_empty=1, FIFO pointers=0, counter16=0, bit_counter=0.
- Advance rule: FSM and counter16 advance only on clk edges where enable=1. FIFO push, flush and count update on any clk edge.
- States: s_idle=0, s_pop=1, s_start=2, s_data=3, s_parity=4, s_stop=5.
- s_idle: on enable with tf_count!=0, go to s_pop; stx_pad_o=1.
- s_pop: one-clk pop pulse; latch the FIFO head into shift reg; compute parity over the bits selected by lcr[1:0]; load bit_counter with word length-1; go to s_start with counter16=15.
- s_start: stx_pad_o=0 for 16 ticks.
- s_data: each bit held 16 ticks, LSB first, then shift; after the last bit go to s_parity if lcr[3] else s_stop.
- s_parity: bit value by {SP,EP}:
  - 00: ~xor (odd parity)
  - 01: xor (even parity)
  - 10: 1 (stick)
  - 11: 0 (stick)
- s_stop: stx_pad_o=1 for 16 ticks if lcr[2]=0; 24 ticks if lcr[2]=1 and 5-bit word; otherwise 32 ticks. Then go to s_idle.
- Back-to-back frames: s_idle with data pending pops on the next enable, giving exactly one extra tick of mark between frames.
- lcr sampling: lcr is sampled in s_pop only. Mid-frame lcr changes take effect next frame, except BC.
- BC (lcr[6]=1): stx_pad_o forced 0 combinationally from the registered value; the FSM keeps running.
- FIFO full (tf_count=FIFO_DEPTH): push is ignored and the count is unchanged.
- Push and pop in the same clk: both occur; count is unchanged. If the FIFO is full, the pop frees the slot and the push is accepted.
- Pop never occurs when the FIFO is empty.
- tx_reset: FIFO empties and tf_count=0 next clk. A frame in flight completes from the shift register. A push coinciding with tx_reset is dropped.
- Reset mid-frame: the line returns to 1 immediately (async).
- Width rule: tf_count saturates at FIFO_DEPTH and never wraps. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined: FIFO_DEPTH-entry FIFO via sub-module; tf_count ranges 0..FIFO_DEPTH.
- Undefined: single 8-bit holding register (16450 mode); tf_count is 0 or 1; push while count=1 is ignored; tx_reset clears the holding register.
- Serial timing is identical in both builds.

Decomposition:
- Shared package/defines: state encodings; LCR bit indices (already in the UART defines header as UART_LC_PE/EP/SP/BC/SB); FIFO width/counter-width constants.
- One natural sub-module: uart_tx_fifo (synchronous RAM-based FIFO with push/pop/flush/count, no error bits), instantiated only under UART_TX_FIFO_EN.

Test Plan:
- lcr=8'h03, push 8'hA5, enable every 4 clks → line: 0, then 1,0,1,0,0,1,0,1, then 1; each bit 16 enables; tx_empty returns to 1 after the stop bit.
- lcr=8'h1B (8E1), push 8'h01 → parity bit 1; lcr=8'h0B (8O1) → parity bit 0; lcr=8'h3B (stick, EP=1) → parity bit 0.
- lcr=8'h04 (5-bit, 1.5 stop), push 8'h1F → 5 data ones, stop high exactly 24 enables; lcr=8'h07 → stop 32 enables.
- Push 17 bytes back-to-back with enable idle → tf_count=16, 17th dropped; enable on → 16 frames sent, each separated by one extra mark tick.
- Mid-frame: assert tx_reset with 5 queued → tf_count=0 next clk, current frame finishes, line then idles; separately assert lcr[6] → stx_pad_o=0 while set.
- Assert wb_rst_i mid-data-bit → stx_pad_o=1, tstate=0, tf_count=0 without waiting for a clk edge.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path.
//   - tx_state_e   : transmitter FSM encoding (also exported on tstate)
//   - UART_LC_*    : bit positions inside the line control register
//   - UART_FIFO_*  : default transmit FIFO geometry
//   - word_mask()  : data-bit mask for an LCR word-length code
package uart_transmitter_pkg;

    localparam int unsigned UART_FIFO_DEPTH   = 16;
    localparam int unsigned UART_FIFO_COUNT_W = 5;

    localparam int unsigned UART_LC_SB = 2;
    localparam int unsigned UART_LC_PE = 3;
    localparam int unsigned UART_LC_EP = 4;
    localparam int unsigned UART_LC_SP = 5;
    localparam int unsigned UART_LC_BC = 6;

    typedef enum logic [2:0] {
        s_idle   = 3'd0,
        s_pop    = 3'd1,
        s_start  = 3'd2,
        s_data   = 3'd3,
        s_parity = 3'd4,
        s_stop   = 3'd5
    } tx_state_e;

    // Word length code 0..3 selects 5..8 data bits.
    function automatic logic [7:0] word_mask(input logic [1:0] wl);
        logic [7:0] m;
        unique case (wl)
            2'd0:    m = 8'h1f;
            2'd1:    m = 8'h3f;
            2'd2:    m = 8'h7f;
            default: m = 8'hff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous RAM-based transmit FIFO.
// Ports:
//   clk, wb_rst_i   clock, asynchronous active-high reset
//   push, data_in   enqueue strobe and byte; ignored when full unless popping
//   pop             dequeue strobe; ignored when empty
//   flush           synchronous clear; a coinciding push is dropped
//   data_out        current head (combinational read)
//   count           occupancy 0..FIFO_DEPTH
module uart_tx_fifo
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned COUNT_W    = UART_FIFO_COUNT_W
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic [COUNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic               do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A pop in the same clock frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && ((count_q != COUNT_W'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= data_in;
    end

    assign data_out = mem[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/uart_transmitter.sv
// 16550-style UART transmit path: THR queue plus serialiser.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single
// 8-bit holding register (16450 mode). Serial timing is the same in both builds.
// Ports:
//   clk, wb_rst_i   clock, asynchronous active-high reset
//   lcr             line control (word length, stop bits, parity, break)
//   wb_dat_i        byte to enqueue, taken on tf_push
//   enable          16x baud tick
//   tx_reset        synchronous queue flush
//   stx_pad_o       serial line, idles high
//   tf_count        queue occupancy
//   tstate          FSM state
//   tx_empty        queue empty and FSM idle
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned COUNT_W    = UART_FIFO_COUNT_W
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic [7:0]         lcr,
    input  logic [7:0]         wb_dat_i,
    input  logic               tf_push,
    input  logic               enable,
    input  logic               tx_reset,
    output logic               stx_pad_o,
    output logic [COUNT_W-1:0] tf_count,
    output logic [2:0]         tstate,
    output logic               tx_empty
);

    tx_state_e  state_q, state_d;
    logic [4:0] counter16_q, counter16_d;   // 5 bits so the 2-stop length (32) fits
    logic [2:0] bit_counter_q, bit_counter_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [1:0] wl_q, wl_d;
    logic       sb_q, sb_d;
    logic       pe_q, pe_d;
    logic       line_q, line_d;
    logic       tf_pop;
    logic [7:0] tf_head;
    logic [4:0] stop_len;
    logic       par_xor;
    logic       unused_lcr7;

    assign unused_lcr7 = lcr[7];

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .COUNT_W    (COUNT_W)
    ) u_fifo (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .push     (tf_push),
        .pop      (tf_pop),
        .flush    (tx_reset),
        .data_in  (wb_dat_i),
        .data_out (tf_head),
        .count    (tf_count)
    );
`else
    logic [7:0] hold_q;
    logic       hold_full_q;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else if (tx_reset) begin
            hold_full_q <= 1'b0;
        end else if (tf_push && (!hold_full_q || tf_pop)) begin
            hold_q      <= wb_dat_i;
            hold_full_q <= 1'b1;
        end else if (tf_pop) begin
            hold_full_q <= 1'b0;
        end
    end

    assign tf_head  = hold_q;
    assign tf_count = COUNT_W'(hold_full_q);
`endif

    // Stop length minus one, in ticks: 16, 24 (1.5 stop with 5-bit word) or 32.
    assign stop_len = !sb_q ? 5'd15 : ((wl_q == 2'd0) ? 5'd23 : 5'd31);
    assign par_xor  = ^(tf_head & word_mask(lcr[1:0]));

    always_comb begin
        state_d       = state_q;
        counter16_d   = counter16_q;
        bit_counter_d = bit_counter_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        wl_d          = wl_q;
        sb_d          = sb_q;
        pe_d          = pe_q;
        tf_pop        = 1'b0;

        unique case (state_q)
            s_idle: begin
                if (enable && (tf_count != '0) && !tx_reset) state_d = s_pop;
            end
            // Not gated by enable: the pop pulse lasts exactly one clk.
            s_pop: begin
                tf_pop        = 1'b1;
                shift_d       = tf_head;
                wl_d          = lcr[1:0];
                sb_d          = lcr[UART_LC_SB];
                pe_d          = lcr[UART_LC_PE];
                bit_counter_d = {1'b0, lcr[1:0]} + 3'd4;
                counter16_d   = 5'd15;
                unique case ({lcr[UART_LC_SP], lcr[UART_LC_EP]})
                    2'b00:   parity_d = ~par_xor;
                    2'b01:   parity_d = par_xor;
                    2'b10:   parity_d = 1'b1;
                    default: parity_d = 1'b0;
                endcase
                state_d = s_start;
            end
            s_start: begin
                if (enable) begin
                    if (counter16_q == '0) begin
                        counter16_d = 5'd15;
                        state_d     = s_data;
                    end else begin
                        counter16_d = counter16_q - 1'b1;
                    end
                end
            end
            s_data: begin
                if (enable) begin
                    if (counter16_q == '0) begin
                        if (bit_counter_q == '0) begin
                            if (pe_q) begin
                                counter16_d = 5'd15;
                                state_d     = s_parity;
                            end else begin
                                counter16_d = stop_len;
                                state_d     = s_stop;
                            end
                        end else begin
                            counter16_d   = 5'd15;
                            shift_d       = {1'b0, shift_q[7:1]};
                            bit_counter_d = bit_counter_q - 1'b1;
                        end
                    end else begin
                        counter16_d = counter16_q - 1'b1;
                    end
                end
            end
            s_parity: begin
                if (enable) begin
                    if (counter16_q == '0) begin
                        counter16_d = stop_len;
                        state_d     = s_stop;
                    end else begin
                        counter16_d = counter16_q - 1'b1;
                    end
                end
            end
            s_stop: begin
                if (enable) begin
                    if (counter16_q == '0) state_d = s_idle;
                    else                   counter16_d = counter16_q - 1'b1;
                end
            end
            default: state_d = s_idle;
        endcase

        // Line value follows the next state so it changes on the same edge as tstate.
        unique case (state_d)
            s_start:  line_d = 1'b0;
            s_data:   line_d = shift_d[0];
            s_parity: line_d = parity_d;
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= s_idle;
            counter16_q   <= '0;
            bit_counter_q <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            wl_q          <= '0;
            sb_q          <= 1'b0;
            pe_q          <= 1'b0;
            line_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            counter16_q   <= counter16_d;
            bit_counter_q <= bit_counter_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            wl_q          <= wl_d;
            sb_q          <= sb_d;
            pe_q          <= pe_d;
            line_q        <= line_d;
        end
    end

    // Break acts on the live LCR so it takes effect mid-frame.
    assign stx_pad_o = line_q & ~lcr[UART_LC_BC];
    assign tstate    = state_q;
    assign tx_empty  = (tf_count == '0) && (state_q == s_idle);

endmodule
